// File: rtl/clock_chip_cfg_pkg.sv
// Shared definitions for the clock-synthesizer Microwire programmer.
// Sequencer states and serial word geometry.
package clock_chip_cfg_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned BIT_CNT_W = $clog2(WORD_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_GAP,
    ST_LOCKWAIT
  } state_t;

endpackage

// File: rtl/clock_chip_cfg_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both flops clear to 0 on reset.
module sync_bit (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clock_chip_cfg.sv
// Programs the board clock synthesizer over Microwire from a synchronous word table,
// then qualifies PLL lock on the synchronized lock-detect pin.
module clock_chip_cfg
  import clock_chip_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned AW          = 4,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned LOCK_TMO    = 1000000
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic [AW:0]   num_words,
  output logic [AW-1:0] tbl_addr,
  input  logic [31:0]   tbl_data,
  output logic          clock_clk,
  output logic          clock_data,
  output logic          clock_le,
  input  logic          clock_ftest_ld,
  output logic          busy,
  output logic          done,
  output logic          locked,
  output logic          error
);

  localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = AW + 1;
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TW = $clog2(LOCK_TMO + 1);

  state_t               state;
  logic [HW-1:0]        half_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [WORD_BITS-1:0] shreg;
  logic [IW-1:0]        index;
  logic [IW-1:0]        words;
  logic [SW-1:0]        stable_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic [SW-1:0]        stable_nxt;
  logic [TW-1:0]        tmo_nxt;
  logic                 ld_sync;
  logic                 half_end;

  sync_bit u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (clock_ftest_ld),
    .q      (ld_sync)
  );

  always_comb begin
    half_end   = (half_cnt == HW'(CLK_DIV - 1));
    stable_nxt = ld_sync ? stable_cnt + SW'(1) : '0;
    tmo_nxt    = tmo_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      index      <= '0;
      words      <= '0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      tbl_addr   <= '0;
      clock_clk  <= 1'b0;
      clock_data <= 1'b0;
      clock_le   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      locked     <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            locked     <= 1'b0;
            error      <= 1'b0;
            index      <= '0;
            words      <= num_words;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
            if (num_words == '0) begin
              state <= ST_LOCKWAIT;
            end else begin
              tbl_addr <= '0;
              state    <= ST_FETCH;
            end
          end else if (locked && !ld_sync) begin
            locked <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          // shreg keeps only the bits still to be sent, next one at the MSB
          clock_data <= tbl_data[WORD_BITS-1];
          shreg      <= {tbl_data[WORD_BITS-2:0], 1'b0};
          clock_clk  <= 1'b0;
          half_cnt   <= '0;
          bit_cnt    <= '0;
          state      <= ST_SHIFT;
        end
        ST_SHIFT: begin
          half_cnt <= half_end ? '0 : half_cnt + HW'(1);
          if (half_end) begin
            if (!clock_clk) begin
              clock_clk <= 1'b1;
            end else begin
              clock_clk <= 1'b0;
              if (bit_cnt == BIT_CNT_W'(WORD_BITS - 1)) begin
                clock_data <= 1'b0;
                clock_le   <= 1'b1;
                state      <= ST_LATCH;
              end else begin
                clock_data <= shreg[WORD_BITS-1];
                shreg      <= {shreg[WORD_BITS-2:0], 1'b0};
                bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end
        end
        ST_LATCH: begin
          half_cnt <= half_end ? '0 : half_cnt + HW'(1);
          if (half_end) begin
            clock_le <= 1'b0;
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          half_cnt <= half_end ? '0 : half_cnt + HW'(1);
          if (half_end) begin
            if (index + IW'(1) == words) begin
              stable_cnt <= '0;
              tmo_cnt    <= '0;
              state      <= ST_LOCKWAIT;
            end else begin
              index    <= index + IW'(1);
              tbl_addr <= index[AW-1:0] + AW'(1);
              state    <= ST_FETCH;
            end
          end
        end
        ST_LOCKWAIT: begin
          stable_cnt <= stable_nxt;
          tmo_cnt    <= tmo_nxt;
          // lock is tested first so a simultaneous timeout still reports lock
          if (stable_nxt == SW'(LOCK_STABLE)) begin
            locked <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else if (tmo_nxt == TW'(LOCK_TMO)) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_chip_cfg.sv
// Bench for clock_chip_cfg: per-cycle comparison against a timeline model of the
// programming sequence, plus a Microwire receiver and hand-computed expectations.
module tb_clock_chip_cfg;

  localparam int unsigned D   = 2;
  localparam int unsigned AW  = 4;
  localparam int unsigned LS  = 8;
  localparam int unsigned TMO = 100;
  localparam int unsigned P   = 2 + 66 * D;
  localparam int unsigned HL  = 16384;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic          ld = 1'b1;
  logic [AW:0]   num_words = '0;
  logic [AW-1:0] tbl_addr;
  logic [31:0]   tbl_data = '0;
  logic          clock_clk, clock_data, clock_le, busy, done, locked, error;
  logic [31:0]   tbl [16];

  clock_chip_cfg #(
    .CLK_DIV     (D),
    .AW          (AW),
    .LOCK_STABLE (LS),
    .LOCK_TMO    (TMO)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .start          (start),
    .num_words      (num_words),
    .tbl_addr       (tbl_addr),
    .tbl_data       (tbl_data),
    .clock_clk      (clock_clk),
    .clock_data     (clock_data),
    .clock_le       (clock_le),
    .clock_ftest_ld (ld),
    .busy           (busy),
    .done           (done),
    .locked         (locked),
    .error          (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Input history as the DUT sees it at each rising edge
  logic        hist_ld [HL];
  logic        hist_st [HL];
  logic [AW:0] hist_nw [HL];

  always @(posedge clk) begin
    cyc = cyc + 1;
    hist_ld[cyc % HL] = nreset & ld;
    hist_st[cyc % HL] = nreset & start;
    hist_nw[cyc % HL] = num_words;
  end

  // Microwire receiver: chip samples data on rising clock, latches on LE
  logic [31:0] rx_sr = '0;
  int          rx_rises = 0;
  int          le_rises = 0;
  logic [31:0] rx_q [$];
  int          le_cyc [$];

  always @(posedge clock_clk) begin
    rx_sr = {rx_sr[30:0], clock_data};
    rx_rises++;
  end

  always @(posedge clock_le) begin
    rx_q.push_back(rx_sr);
    le_cyc.push_back(cyc);
    le_rises++;
  end

  // Timeline model: a sequence accepted at edge A shows word w, bit b at offsets
  // w*P + 2 + b*2D .. +2D-1 (low half then high half), LE for D cycles after bit 31.
  bit            m_act = 1'b0;
  int            m_a, m_n, m_cend, m_run;
  logic [31:0]   m_words [16];
  logic          m_locked = 1'b0;
  logic          m_error = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int            done_cnt = 0;
  int            le_run = 0;
  int            le_w = 0;

  always @(negedge clk) begin
    int c, w, s, ss;
    logic e_clk, e_data, e_le, e_busy, e_done;
    e_clk = 1'b0; e_data = 1'b0; e_le = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (!nreset) begin
      m_act = 1'b0; m_locked = 1'b0; m_error = 1'b0; m_addr = '0;
    end else begin
      if (!m_act) begin
        if (m_locked && !hist_ld[(cyc + HL - 2) % HL]) m_locked = 1'b0;
        if (hist_st[cyc % HL]) begin
          m_act = 1'b1; m_a = cyc; m_n = int'(hist_nw[cyc % HL]);
          m_cend = m_n * P; m_run = 0; m_locked = 1'b0; m_error = 1'b0;
          for (int i = 0; i < 16; i++) m_words[i] = tbl[i];
          if (m_n != 0) m_addr = '0;
        end
      end else begin
        c = cyc - m_a;
        if (c > m_cend) begin
          m_run = hist_ld[(cyc + HL - 2) % HL] ? m_run + 1 : 0;
          if (m_run == LS) begin
            m_locked = 1'b1; e_done = 1'b1; m_act = 1'b0;
          end else if (c - m_cend == TMO) begin
            m_error = 1'b1; e_done = 1'b1; m_act = 1'b0;
          end
        end
      end
      if (m_act) begin
        c = cyc - m_a;
        e_busy = 1'b1;
        if (c < m_cend) begin
          w = c / P; s = c % P;
          m_addr = AW'(w);
          if (s >= 2 && s < 2 + 64 * D) begin
            ss = s - 2;
            e_clk  = (ss % (2 * D)) >= D;
            e_data = m_words[w][31 - ss / (2 * D)];
          end else if (s >= 2 + 64 * D && s < 2 + 65 * D) begin
            e_le = 1'b1;
          end
        end
      end
    end
    check("clock_clk", clock_clk, e_clk);
    check("clock_data", clock_data, e_data);
    check("clock_le", clock_le, e_le);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("locked", locked, m_locked);
    check("error", error, m_error);
    check("tbl_addr", tbl_addr, m_addr);
    if (done) done_cnt++;
    if (clock_le) le_run++;
    else if (le_run > 0) begin le_w = le_run; le_run = 0; end
  end

  int t_acc = 0;
  int done_off = 0;

  task automatic clear_obs();
    rx_rises = 0; le_rises = 0; done_cnt = 0; le_w = 0;
    rx_q.delete(); le_cyc.delete();
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    num_words = 5'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(input string name, input int budget, input bit toggle);
    int k = 0;
    int tg = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
      if (toggle) begin
        tg++;
        if (tg == 5) begin tg = 0; ld = ~ld; end
      end
    end
    if (!done) check({name, "_done_timeout"}, 32'd0, 32'd1);
    done_off = cyc - t_acc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp3 [3];
    int clr;
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    for (int i = 0; i < int'(HL); i++) begin hist_ld[i] = 1'b0; hist_st[i] = 1'b0; hist_nw[i] = '0; end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_clk", clock_clk, 1'b0);
    check("rst_le", clock_le, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_addr", tbl_addr, '0);
    nreset = 1'b1;
    repeat (3) @(negedge clk);

    // single word
    tbl[0] = 32'hA500_0001;
    clear_obs();
    do_start(1);
    wait_done("t1", 400, 1'b0);
    check("t1_le_cnt", le_rises, 1);
    if (rx_q.size() > 0) check("t1_word", rx_q[0], 32'hA500_0001);
    check("t1_rises", rx_rises, 32);
    check("t1_le_width", le_w, 2);
    check("t1_done_off", done_off, 142);
    check("t1_locked", locked, 1'b1);
    repeat (3) @(negedge clk);
    check("t1_done_cnt", done_cnt, 1);

    // three words
    exp3[0] = 32'h0000_0001; exp3[1] = 32'h8000_0000; exp3[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) tbl[i] = exp3[i];
    clear_obs();
    do_start(3);
    wait_done("t2", 1000, 1'b0);
    check("t2_le_cnt", le_rises, 3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++) check("t2_word", rx_q[i], exp3[i]);
    if (le_cyc.size() == 3) begin
      check("t2_le_gap01", le_cyc[1] - le_cyc[0], 134);
      check("t2_le_gap12", le_cyc[2] - le_cyc[1], 134);
    end
    check("t2_addr", tbl_addr, 4'd2);
    check("t2_done_off", done_off, 410);

    // zero words
    clear_obs();
    do_start(0);
    wait_done("t3", 50, 1'b0);
    check("t3_rises", rx_rises, 0);
    check("t3_le_cnt", le_rises, 0);
    check("t3_done_off", done_off, 8);
    check("t3_locked", locked, 1'b1);

    // one-cycle loss of lock while idle
    @(negedge clk);
    ld = 1'b0;
    clr = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ld = 1'b1;
      if (!locked && clr == 0) clr = k;
    end
    check("t5_clear_cycles", clr, 3);
    check("t5_error", error, 1'b0);

    // timeout with ld held low
    ld = 1'b0;
    repeat (4) @(negedge clk);
    do_start(0);
    wait_done("t4", 200, 1'b0);
    check("t4_done_off", done_off, 100);
    check("t4_error", error, 1'b1);
    check("t4_locked", locked, 1'b0);

    // lock and timeout on the same cycle: lock wins
    do_start(0);
    repeat (90) @(negedge clk);
    ld = 1'b1;
    wait_done("t6", 200, 1'b0);
    check("t6_done_off", done_off, 100);
    check("t6_locked", locked, 1'b1);
    check("t6_error", error, 1'b0);

    // ld toggling every 5 cycles never qualifies
    ld = 1'b0;
    repeat (4) @(negedge clk);
    do_start(0);
    wait_done("t7", 300, 1'b1);
    check("t7_done_off", done_off, 100);
    check("t7_error", error, 1'b1);
    check("t7_locked", locked, 1'b0);

    // start re-pulsed mid-shift is ignored
    ld = 1'b1;
    repeat (4) @(negedge clk);
    tbl[0] = 32'hA500_0001; tbl[1] = 32'h5A00_00FE;
    clear_obs();
    do_start(2);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t8", 600, 1'b0);
    check("t8_le_cnt", le_rises, 2);
    if (rx_q.size() == 2) begin
      check("t8_word0", rx_q[0], 32'hA500_0001);
      check("t8_word1", rx_q[1], 32'h5A00_00FE);
    end
    check("t8_done_off", done_off, 276);

    // reset asserted mid-shift, then a clean rerun
    tbl[0] = 32'hFFFF_FFFF;
    clear_obs();
    do_start(1);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #2 nreset = 1'b0;
    #1;
    check("r_clk", clock_clk, 1'b0);
    check("r_data", clock_data, 1'b0);
    check("r_le", clock_le, 1'b0);
    check("r_busy", busy, 1'b0);
    check("r_done", done, 1'b0);
    check("r_locked", locked, 1'b0);
    check("r_error", error, 1'b0);
    check("r_addr", tbl_addr, '0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 nreset = 1'b1;
    check("r_no_partial_le", le_rises, 0);
    repeat (3) @(negedge clk);
    tbl[0] = 32'h1234_5678;
    clear_obs();
    do_start(1);
    wait_done("t9", 400, 1'b0);
    check("t9_le_cnt", le_rises, 1);
    if (rx_q.size() > 0) check("t9_word", rx_q[0], 32'h1234_5678);
    check("t9_rises", rx_rises, 32);
    check("t9_done_off", done_off, 142);
    check("t9_locked", locked, 1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
